vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Front-end controller for the gum vending path.
- Arbitrates coin events from NSLOT independent coin slots onto one shared credit accumulator, one coin per cycle, using round-robin.
- When credit reaches PRICE, it sequences the dispense motor (pulse, then wait for done) and blocks all slots until the motor finishes.
- Sits between the slot sensors and the dispense actuator.

Parameters:
- NSLOT, 2: number of coin slots (requesters), 2..8.
- PRICE, 15: item price in cents; must be a multiple of 5.
- CREDIT_W, 6: credit register width; must hold PRICE+5.
- TIMEOUT_CYC, 16: maximum WAIT_DONE cycles before entering FAULT.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- coin_valid, input, NSLOT: slot i holds a coin.
- coin_type, input, 2*NSLOT: coin code per slot; slot i uses bits [2i+1:2i]. 01 = nickel, 10 = dime, 00/11 = invalid.
- coin_ready, output, NSLOT: one-hot grant; a coin transfers when valid&ready.
- credit, output, CREDIT_W: current credit in cents.
- dispense, output, 1: one-cycle motor start pulse.
- motor_done, input, 1: motor finished; level or pulse.
- reject, output, 1: one-cycle pulse, invalid coin code consumed.
- fault, output, 1: motor timeout; sticky until rst.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - state = COLLECT, credit = 0, rr_ptr = 0, timeout counter = 0.
  - dispense, reject and fault = 0.
  - coin_ready = 0 in the reset cycle.
- States: COLLECT, DISPENSE, WAIT_DONE, FAULT. Encoding lives in the package.
- Arbitration (COLLECT only):
  - Grant goes to the first slot with coin_valid set, searching upward from rr_ptr with wrap.
  - coin_ready is combinational from coin_valid and rr_ptr; at most one bit is set.
  - On transfer, rr_ptr becomes grant+1 modulo NSLOT. With no transfer, rr_ptr holds.
  - coin_ready is all-zero in every other state.
- Credit update, on a transfer at cycle N:
  - nickel adds 5, dime adds 10, visible on credit at N+1.
  - Invalid code: coin is consumed, credit is unchanged, reject = 1 at N+1 for one cycle.
- Dispense:
  - If the updated credit is >= PRICE, state is DISPENSE at N+1.
  - dispense = 1 exactly while state == DISPENSE, which is one cycle.
  - credit shows the full total in the DISPENSE cycle and is cleared to 0 at N+2 (no change given).
  - State then goes to WAIT_DONE.
- WAIT_DONE:
  - Counter increments every cycle.
  - motor_done = 1 moves to COLLECT next cycle and clears the counter.
  - If the counter reaches TIMEOUT_CYC-1 without motor_done, next state is FAULT. If motor_done is seen in that same cycle, motor_done wins.
- FAULT:
  - fault = 1, all slots blocked, credit held at 0.
  - Exit only via rst.
- motor_done outside WAIT_DONE is ignored.
- Only one coin is consumed per cycle, even if every slot is valid. Losing slots keep valid asserted and wait for a grant.
- Maximum credit is PRICE+5: a dime at PRICE-5. No overflow is possible given the CREDIT_W rule.
- rst mid-operation (any state) discards credit and any pending motor wait.
- dispense, reject and fault are registered outputs with no glitches.

Optional Feature:
- Macro: VEND_CHANGE_EN.
- Defined:
  - Adds output change_nickels, width 2, registered.
  - In the DISPENSE cycle it equals (credit-PRICE)/5 (0 or 1); it is 0 otherwise.
  - Example: dime+dime at PRICE 15 gives change_nickels = 1 alongside dispense.
- Undefined:
  - The port is absent, and excess credit is forfeited.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t.
  - coin code constants COIN_NONE/COIN_NICKEL/COIN_DIME.
  - cent values NICKEL_C = 5 and DIME_C = 10.
- Sub-module rr_arbiter (parameter N):
  - inputs req, ptr, en; outputs one-hot gnt and the grant index.
  - Instantiated once.
- The FSM, credit register and timeout counter stay in vend_sequencer.

Test Plan:
- Nickel, nickel, nickel on slot 0:
  - credit steps 5, 10, 15.
  - dispense = 1 in the cycle credit = 15; credit = 0 next cycle.
  - Assert motor_done, then state returns to COLLECT.
- Slots 0 and 1 both valid with nickels, held for 3 cycles starting from rr_ptr = 0:
  - grants alternate slot0, slot1, slot0.
  - the third coin dispenses and both ready bits drop.
- Nickel then dime:
  - credit 5 then 15, dispense pulse.
  - Coins offered during WAIT_DONE see coin_ready = 0 until motor_done.
- Coin code 11 on slot 1:
  - transfer occurs, reject = 1 for one cycle, credit unchanged.
- After dispense, hold motor_done = 0 for TIMEOUT_CYC cycles:
  - fault = 1 and stays high with valid coins present, ready = 0.
  - rst clears it and credit = 0.
- With VEND_CHANGE_EN, dime then dime:
  - credit = 20, dispense = 1, change_nickels = 1 in the same cycle.
  - Also assert rst during WAIT_DONE: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the gum vending front end.
// Holds the sequencer state encoding, coin codes and coin cent values.
// Imported by vend_sequencer; rr_arbiter has no package dependency.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    DISPENSE  = 2'd1,
    WAIT_DONE = 2'd2,
    FAULT     = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  localparam int NICKEL_C = 5;
  localparam int DIME_C   = 10;

  // Cent value of a coin code; zero marks a code that must be rejected.
  function automatic int coin_cents(input logic [1:0] code);
    case (code)
      COIN_NICKEL: return NICKEL_C;
      COIN_DIME:   return DIME_C;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one requester, search starts at ptr.
// Ports: req (requests), ptr (highest-priority index), en (gate) -> gnt (one-hot), idx.
// Latency 0; with en low gnt is all-zero and idx is 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        // Walk upward from ptr with wrap; first requester seen wins.
        j = (int'(ptr) + k) % N;
        if (!found && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: arbitrates NSLOT coin slots onto one credit register and runs the
// dispense motor handshake. Ports: clk/rst, coin_valid/coin_type/coin_ready per slot,
// credit, dispense/reject/fault pulses and flags, motor_done from the actuator.
// One coin per cycle; all slots blocked outside COLLECT. Optional change output
// change_nickels is built when VEND_CHANGE_EN is defined.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int NSLOT       = 2,
  parameter int PRICE       = 15,
  parameter int CREDIT_W    = 6,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSLOT-1:0]      coin_valid,
  input  logic [2*NSLOT-1:0]    coin_type,
  output logic [NSLOT-1:0]      coin_ready,
  output logic [CREDIT_W-1:0]   credit,
  output logic                  dispense,
  input  logic                  motor_done,
  output logic                  reject,
`ifdef VEND_CHANGE_EN
  output logic [1:0]            change_nickels,
`endif
  output logic                  fault
);

  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  vend_state_t          state;
  logic [PW-1:0]        rr_ptr;
  logic [TW-1:0]        tcnt;

  logic [NSLOT-1:0]     gnt;
  logic [PW-1:0]        gidx;
  logic                 xfer;
  logic [1:0]           gcode;
  logic [CREDIT_W-1:0]  cents;
  logic                 bad_coin;
  logic [CREDIT_W-1:0]  sum;

  // Grants are suppressed during reset so no coin is taken in the reset cycle.
  rr_arbiter #(.N(NSLOT), .PW(PW)) u_arb (
    .req (coin_valid),
    .ptr (rr_ptr),
    .en  ((state == COLLECT) && !rst),
    .gnt (gnt),
    .idx (gidx)
  );

  assign coin_ready = gnt;
  assign xfer       = |gnt;
  assign gcode      = coin_type[2*int'(gidx) +: 2];
  assign cents      = CREDIT_W'(coin_cents(gcode));
  assign bad_coin   = (cents == '0);
  assign sum        = credit + cents;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      credit   <= '0;
      rr_ptr   <= '0;
      tcnt     <= '0;
      dispense <= 1'b0;
      reject   <= 1'b0;
      fault    <= 1'b0;
`ifdef VEND_CHANGE_EN
      change_nickels <= 2'd0;
`endif
    end else begin
      dispense <= 1'b0;
      reject   <= 1'b0;
`ifdef VEND_CHANGE_EN
      change_nickels <= 2'd0;
`endif
      case (state)
        COLLECT: begin
          if (xfer) begin
            rr_ptr <= (int'(gidx) == NSLOT - 1) ? '0 : gidx + PW'(1);
            // Invalid codes are swallowed: the coin is taken but earns nothing.
            reject <= bad_coin;
            if (!bad_coin) begin
              credit <= sum;
              if (sum >= CREDIT_W'(PRICE)) begin
                state    <= DISPENSE;
                dispense <= 1'b1;
`ifdef VEND_CHANGE_EN
                change_nickels <= 2'((sum - CREDIT_W'(PRICE)) / CREDIT_W'(NICKEL_C));
`endif
              end
            end
          end
        end
        DISPENSE: begin
          // Excess credit is consumed with the sale (returned as change when built in).
          credit <= '0;
          tcnt   <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // motor_done takes priority over a timeout in the same cycle.
          if (motor_done) begin
            state <= COLLECT;
            tcnt  <= '0;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        FAULT: begin
          credit <= '0;
          fault  <= 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scenario tasks drive hand-derived stimulus rows for vend_sequencer
// (NSLOT=2, PRICE=15, TIMEOUT_CYC=16). Each row carries its expected outcome, which is
// queued when driven and popped for comparison once the clock edge has produced output.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_valid;
  logic [3:0] coin_type;
  logic [1:0] coin_ready;
  logic [5:0] credit;
  logic       dispense;
  logic       motor_done;
  logic       reject;
  logic       fault;
`ifdef VEND_CHANGE_EN
  logic [1:0] change_nickels;
`endif

  vend_sequencer #(.NSLOT(2), .PRICE(15), .CREDIT_W(6), .TIMEOUT_CYC(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .coin_ready     (coin_ready),
    .credit         (credit),
    .dispense       (dispense),
    .motor_done     (motor_done),
    .reject         (reject),
`ifdef VEND_CHANGE_EN
    .change_nickels (change_nickels),
`endif
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // ready is the pre-edge grant for this row; the other fields are post-edge values.
  typedef struct packed {
    logic       rst;
    logic [1:0] valid;
    logic [3:0] ctype;
    logic       done;
    logic [1:0] ready;
    logic [5:0] credit;
    logic       disp;
    logic       rej;
    logic       fault;
    logic [1:0] chg;
  } row_t;

  row_t       sb[$];
  logic [1:0] obs_ready;
  int         passes = 0;
  int         total  = 0;

  // Coin type nibbles: slot1 in [3:2], slot0 in [1:0].
  localparam logic [3:0] N0   = 4'b0001;
  localparam logic [3:0] D0   = 4'b0010;
  localparam logic [3:0] NN   = 4'b0101;
  localparam logic [3:0] N1   = 4'b0100;
  localparam logic [3:0] BAD1 = 4'b1100;

  function automatic row_t mk(input logic r, input logic [1:0] v, input logic [3:0] t,
                              input logic d, input logic [1:0] rdy, input int c,
                              input logic di, input logic rj, input logic f,
                              input logic [1:0] ch = 2'd0);
    row_t x;
    x.rst = r; x.valid = v; x.ctype = t; x.done = d; x.ready = rdy;
    x.credit = 6'(c); x.disp = di; x.rej = rj; x.fault = f; x.chg = ch;
    return x;
  endfunction

  function automatic string fmt(input logic [1:0] rdy, input logic [5:0] c,
                                input logic di, input logic rj, input logic f);
    return $sformatf("ready=%b credit=%0d dispense=%b reject=%b fault=%b", rdy, c, di, rj, f);
  endfunction

  // Drive one cycle: queue the expectation, apply inputs, sample grant before the edge.
  task automatic cyc(input row_t r);
    sb.push_back(r);
    rst        = r.rst;
    coin_valid = r.valid;
    coin_type  = r.ctype;
    motor_done = r.done;
    #3;
    obs_ready = coin_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 2'b11, NN, 1, 2'b00, 0, 0, 0, 0));
    rows.push_back(mk(1, 2'b11, NN, 0, 2'b00, 0, 0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL reset[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  task automatic test_nickels();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 10, 0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 15, 1, 0, 0));
    rows.push_back(mk(0, 2'b00, N0, 0, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b00, N0, 1, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5,  0, 0, 0));
    rows.push_back(mk(1, 2'b00, N0, 0, 2'b00, 0,  0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL nickels[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b11, NN, 0, 2'b01, 5,  0, 0, 0));
    rows.push_back(mk(0, 2'b11, NN, 0, 2'b10, 10, 0, 0, 0));
    rows.push_back(mk(0, 2'b11, NN, 0, 2'b01, 15, 1, 0, 0));
    rows.push_back(mk(0, 2'b11, NN, 0, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b11, NN, 1, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(1, 2'b00, NN, 0, 2'b00, 0,  0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL round_robin[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  task automatic test_nickel_dime();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 15, 1, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 1, 2'b00, 0,  0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 10, 0, 0, 0));
    rows.push_back(mk(1, 2'b00, D0, 0, 2'b00, 0,  0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL nickel_dime[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  // Also shows motor_done is ignored while collecting.
  task automatic test_reject();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b10, BAD1, 0, 2'b10, 0, 0, 1, 0));
    rows.push_back(mk(0, 2'b00, BAD1, 0, 2'b00, 0, 0, 0, 0));
    rows.push_back(mk(0, 2'b10, N1,   0, 2'b10, 5, 0, 0, 0));
    rows.push_back(mk(0, 2'b10, BAD1, 0, 2'b10, 5, 0, 1, 0));
    rows.push_back(mk(0, 2'b00, BAD1, 1, 2'b00, 5, 0, 0, 0));
    rows.push_back(mk(1, 2'b00, BAD1, 0, 2'b00, 0, 0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL reject[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  // 16 waiting cycles without motor_done end in FAULT; FAULT holds until rst.
  task automatic test_timeout();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 10, 0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 15, 1, 0, 0));
    rows.push_back(mk(0, 2'b00, N0, 0, 2'b00, 0,  0, 0, 0));
    for (int k = 0; k < 16; k++)
      rows.push_back(mk(0, 2'b11, NN, 0, 2'b00, 0, 0, 0, (k == 15)));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(0, 2'b11, NN, 1, 2'b00, 0, 0, 0, 1));
    rows.push_back(mk(1, 2'b11, NN, 0, 2'b00, 0, 0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5, 0, 0, 0));
    rows.push_back(mk(1, 2'b00, N0, 0, 2'b00, 0, 0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL timeout[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

  // motor_done arriving in the last allowed waiting cycle beats the timeout.
  task automatic test_done_at_limit();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 10, 0, 0, 0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 20, 1, 0, 0));
    rows.push_back(mk(0, 2'b00, D0, 0, 2'b00, 0,  0, 0, 0));
    for (int k = 0; k < 15; k++)
      rows.push_back(mk(0, 2'b00, D0, 0, 2'b00, 0, 0, 0, 0));
    rows.push_back(mk(0, 2'b00, D0, 1, 2'b00, 0, 0, 0, 0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5, 0, 0, 0));
    rows.push_back(mk(1, 2'b00, N0, 0, 2'b00, 0, 0, 0, 0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault} !== {e.ready, e.credit, e.disp, e.rej, e.fault})
        $display("FAIL done_at_limit[%0d]: got %s, want %s", i, fmt(obs_ready, credit, dispense, reject, fault),
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault));
      else passes++;
    end
  endtask

`ifdef VEND_CHANGE_EN
  // Dime+dime returns one nickel; rst during WAIT_DONE restores reset values.
  task automatic test_change();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 10, 0, 0, 0, 2'd0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 20, 1, 0, 0, 2'd1));
    rows.push_back(mk(0, 2'b00, D0, 0, 2'b00, 0,  0, 0, 0, 2'd0));
    rows.push_back(mk(1, 2'b11, NN, 0, 2'b00, 0,  0, 0, 0, 2'd0));
    rows.push_back(mk(0, 2'b01, N0, 0, 2'b01, 5,  0, 0, 0, 2'd0));
    rows.push_back(mk(0, 2'b01, D0, 0, 2'b01, 15, 1, 0, 0, 2'd0));
    rows.push_back(mk(1, 2'b00, D0, 0, 2'b00, 0,  0, 0, 0, 2'd0));
    foreach (rows[i]) begin
      cyc(rows[i]);
      e = sb.pop_front();
      total++;
      if ({obs_ready, credit, dispense, reject, fault, change_nickels} !==
          {e.ready, e.credit, e.disp, e.rej, e.fault, e.chg})
        $display("FAIL change[%0d]: got %s change=%0d, want %s change=%0d", i,
                 fmt(obs_ready, credit, dispense, reject, fault), change_nickels,
                 fmt(e.ready, e.credit, e.disp, e.rej, e.fault), e.chg);
      else passes++;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passes, total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    coin_valid = '0;
    coin_type  = '0;
    motor_done = 1'b0;
    test_reset();
    test_nickels();
    test_round_robin();
    test_nickel_dime();
    test_reject();
    test_timeout();
    test_done_at_limit();
`ifdef VEND_CHANGE_EN
    test_change();
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
